// File: rtl/http_tx_arbiter_pkg.sv
// Shared types for the HTTP transmit arbiter: TCP meta/status payloads and
// the error and completion encodings.
package http_tx_arbiter_pkg;

    localparam int unsigned META_W   = 32;
    localparam int unsigned STATUS_W = 64;
    localparam int unsigned DONE_W   = 2;

    typedef struct packed {
        logic [15:0] length;
        logic [15:0] session;
    } tx_meta_t;

    typedef enum logic [1:0] {
        ERR_OK       = 2'd0,
        ERR_NO_SPACE = 2'd1,
        ERR_NO_CONN  = 2'd2,
        ERR_RESERVED = 2'd3
    } tx_error_e;

    typedef struct packed {
        tx_error_e   error;
        logic [29:0] space;
        logic [15:0] length;
        logic [15:0] session;
    } tx_status_t;

    typedef enum logic [1:0] {
        DONE_SENT     = 2'd0,
        DONE_NO_SPACE = 2'd1,
        DONE_NO_CONN  = 2'd2,
        DONE_ZERO_LEN = 2'd3
    } done_code_e;

    // A status belongs to the outstanding request only if session and length both agree.
    function automatic logic status_match(input logic [STATUS_W-1:0] raw, input tx_meta_t meta);
        tx_status_t st;
        st = tx_status_t'(raw);
        return (st.session == meta.session) && (st.length == meta.length);
    endfunction

    function automatic tx_error_e status_error(input logic [STATUS_W-1:0] raw);
        tx_status_t st;
        st = tx_status_t'(raw);
        return st.error;
    endfunction

endpackage

// File: rtl/http_tx_arbiter_if.sv
// Channel-side and TCP-side handshake bundle of the transmit arbiter.
interface http_tx_arbiter_if #(
    parameter int unsigned N_CH       = 4,
    parameter int unsigned DATA_WIDTH = 512
);
    import http_tx_arbiter_pkg::*;

    logic [N_CH-1:0]                  ch_meta_valid;
    logic [N_CH-1:0]                  ch_meta_ready;
    logic [META_W*N_CH-1:0]           ch_meta_data;
    logic [N_CH-1:0]                  ch_data_valid;
    logic [N_CH-1:0]                  ch_data_ready;
    logic [DATA_WIDTH*N_CH-1:0]       ch_data_data;
    logic [DATA_WIDTH/8*N_CH-1:0]     ch_data_keep;
    logic [N_CH-1:0]                  ch_data_last;
    logic [N_CH-1:0]                  ch_done_valid;
    logic [DONE_W-1:0]                ch_done_code;

    logic                             tcp_tx_meta_valid;
    logic                             tcp_tx_meta_ready;
    logic [META_W-1:0]                tcp_tx_meta_data;
    logic                             tcp_tx_status_valid;
    logic                             tcp_tx_status_ready;
    logic [STATUS_W-1:0]              tcp_tx_status_data;
    logic                             tcp_tx_data_valid;
    logic                             tcp_tx_data_ready;
    logic [DATA_WIDTH-1:0]            tcp_tx_data_data;
    logic [DATA_WIDTH/8-1:0]          tcp_tx_data_keep;
    logic                             tcp_tx_data_last;

    modport master (
        input  ch_meta_valid, ch_meta_data,
        input  ch_data_valid, ch_data_data, ch_data_keep, ch_data_last,
        output ch_meta_ready, ch_data_ready, ch_done_valid, ch_done_code,
        output tcp_tx_meta_valid, tcp_tx_meta_data,
        input  tcp_tx_meta_ready,
        input  tcp_tx_status_valid, tcp_tx_status_data,
        output tcp_tx_status_ready,
        output tcp_tx_data_valid, tcp_tx_data_data, tcp_tx_data_keep, tcp_tx_data_last,
        input  tcp_tx_data_ready
    );

    modport slave (
        output ch_meta_valid, ch_meta_data,
        output ch_data_valid, ch_data_data, ch_data_keep, ch_data_last,
        input  ch_meta_ready, ch_data_ready, ch_done_valid, ch_done_code,
        input  tcp_tx_meta_valid, tcp_tx_meta_data,
        output tcp_tx_meta_ready,
        output tcp_tx_status_valid, tcp_tx_status_data,
        input  tcp_tx_status_ready,
        input  tcp_tx_data_valid, tcp_tx_data_data, tcp_tx_data_keep, tcp_tx_data_last,
        output tcp_tx_data_ready
    );

endinterface

// File: rtl/http_tx_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first requester at or after ptr, wrapping.
module http_tx_arbiter_rr_arbiter #(
    parameter int unsigned N     = 4,
    parameter int unsigned IDX_W = 2
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     grant_c,
    output logic [IDX_W-1:0] idx_c,
    output logic             valid_c
);

    int unsigned cand;

    always_comb begin
        grant_c = '0;
        idx_c   = '0;
        valid_c = 1'b0;
        cand    = 0;
        for (int unsigned off = 0; off < N; off++) begin
            cand = (32'(ptr) + off) % N;
            if (!valid_c && req[cand]) begin
                valid_c       = 1'b1;
                grant_c[cand] = 1'b1;
                idx_c         = IDX_W'(cand);
            end
        end
    end

endmodule

// File: rtl/http_tx_arbiter.sv
// Multi-channel HTTP response transmit arbiter: round-robin grant, TCP meta/status
// exchange with bounded no-space retries, then payload pass-through or drain.
module http_tx_arbiter
    import http_tx_arbiter_pkg::*;
#(
    parameter int unsigned N_CH           = 4,
    parameter int unsigned DATA_WIDTH     = 512,
    parameter int unsigned BACKOFF_CYCLES = 64,
    parameter int unsigned MAX_RETRIES    = 8
) (
    input logic                ap_clk,
    input logic                ap_rst,
    http_tx_arbiter_if.master  bus
);

    localparam int unsigned IDX_W     = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int unsigned KEEP_W    = DATA_WIDTH / 8;
    localparam int unsigned RETRY_W   = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;
    localparam int unsigned BACKOFF_W = (BACKOFF_CYCLES > 1) ? $clog2(BACKOFF_CYCLES) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_META, S_STATUS, S_BACKOFF, S_STREAM, S_DROP
    } state_e;

    state_e               state_q, state_d;
    logic [IDX_W-1:0]     g_q, g_d;
    logic [IDX_W-1:0]     ptr_q, ptr_d;
    logic [RETRY_W-1:0]   retries_q, retries_d;
    logic [BACKOFF_W-1:0] backoff_q, backoff_d;
    tx_meta_t             meta_q, meta_d;
    done_code_e           code_q, code_d;
    logic [7:0]           mismatch_q, mismatch_d;
    logic [N_CH-1:0]      done_valid_q;
    done_code_e           done_code_q;

    logic                 done_fire;
    logic [IDX_W-1:0]     done_idx;
    done_code_e           done_code_d;

    logic [N_CH-1:0]      arb_req;
    logic [N_CH-1:0]      arb_grant;
    logic [IDX_W-1:0]     arb_idx;
    logic                 arb_valid;
    tx_meta_t             meta_in;

    logic [N_CH-1:0]      g_onehot;
    logic                 g_valid;
    logic                 g_last;

    // No grant may be offered while reset is held, even with requests pending.
    assign arb_req = ap_rst ? '0 : bus.ch_meta_valid;

    http_tx_arbiter_rr_arbiter #(
        .N     (N_CH),
        .IDX_W (IDX_W)
    ) u_rr (
        .req     (arb_req),
        .ptr     (ptr_q),
        .grant_c (arb_grant),
        .idx_c   (arb_idx),
        .valid_c (arb_valid)
    );

    assign meta_in  = tx_meta_t'(bus.ch_meta_data[META_W*arb_idx +: META_W]);
    assign g_onehot = N_CH'(1) << g_q;
    assign g_valid  = bus.ch_data_valid[g_q];
    assign g_last   = bus.ch_data_last[g_q];

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            state_q      <= S_IDLE;
            g_q          <= '0;
            ptr_q        <= '0;
            retries_q    <= '0;
            backoff_q    <= '0;
            meta_q       <= '0;
            code_q       <= DONE_SENT;
            mismatch_q   <= '0;
            done_valid_q <= '0;
            done_code_q  <= DONE_SENT;
        end else begin
            state_q      <= state_d;
            g_q          <= g_d;
            ptr_q        <= ptr_d;
            retries_q    <= retries_d;
            backoff_q    <= backoff_d;
            meta_q       <= meta_d;
            code_q       <= code_d;
            mismatch_q   <= mismatch_d;
            done_valid_q <= done_fire ? (N_CH'(1) << done_idx) : '0;
            done_code_q  <= done_fire ? done_code_d : DONE_SENT;
        end
    end

    always_comb begin
        state_d     = state_q;
        g_d         = g_q;
        ptr_d       = ptr_q;
        retries_d   = retries_q;
        backoff_d   = backoff_q;
        meta_d      = meta_q;
        code_d      = code_q;
        mismatch_d  = mismatch_q;
        done_fire   = 1'b0;
        done_idx    = g_q;
        done_code_d = DONE_SENT;

        case (state_q)
            S_IDLE: begin
                if (arb_valid) begin
                    g_d       = arb_idx;
                    meta_d    = meta_in;
                    ptr_d     = (arb_idx == IDX_W'(N_CH - 1)) ? '0 : arb_idx + IDX_W'(1);
                    retries_d = '0;
                    // Zero-length responses never reach TCP; report them straight back.
                    if (meta_in.length == 16'd0) begin
                        done_fire   = 1'b1;
                        done_idx    = arb_idx;
                        done_code_d = DONE_ZERO_LEN;
                    end else begin
                        state_d = S_META;
                    end
                end
            end
            S_META: begin
                if (bus.tcp_tx_meta_ready) state_d = S_STATUS;
            end
            S_STATUS: begin
                if (bus.tcp_tx_status_valid) begin
                    if (status_match(bus.tcp_tx_status_data, meta_q)) begin
                        case (status_error(bus.tcp_tx_status_data))
                            ERR_OK: state_d = S_STREAM;
                            ERR_NO_SPACE: begin
                                if (retries_q < RETRY_W'(MAX_RETRIES)) begin
                                    retries_d = retries_q + RETRY_W'(1);
                                    backoff_d = '0;
                                    state_d   = S_BACKOFF;
                                end else begin
                                    code_d  = DONE_NO_SPACE;
                                    state_d = S_DROP;
                                end
                            end
                            default: begin
                                code_d  = DONE_NO_CONN;
                                state_d = S_DROP;
                            end
                        endcase
                    end else if (mismatch_q != 8'hFF) begin
                        mismatch_d = mismatch_q + 8'd1;
                    end
                end
            end
            S_BACKOFF: begin
                if (backoff_q == BACKOFF_W'(BACKOFF_CYCLES - 1)) begin
                    state_d = S_META;
                end else begin
                    backoff_d = backoff_q + BACKOFF_W'(1);
                end
            end
            S_STREAM: begin
                if (g_valid && bus.tcp_tx_data_ready && g_last) begin
                    done_fire   = 1'b1;
                    done_code_d = DONE_SENT;
                    state_d     = S_IDLE;
                end
            end
            S_DROP: begin
                if (g_valid && g_last) begin
                    done_fire   = 1'b1;
                    done_code_d = code_q;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign bus.ch_meta_ready       = (state_q == S_IDLE) ? arb_grant : '0;
    assign bus.ch_data_ready       = (state_q == S_STREAM) ? (g_onehot & {N_CH{bus.tcp_tx_data_ready}})
                                   : (state_q == S_DROP)   ? g_onehot : '0;
    assign bus.ch_done_valid       = done_valid_q;
    assign bus.ch_done_code        = DONE_W'(done_code_q);

    assign bus.tcp_tx_meta_valid   = (state_q == S_META);
    assign bus.tcp_tx_meta_data    = META_W'(meta_q);
    assign bus.tcp_tx_status_ready = (state_q == S_STATUS);

    // Payload is a straight pass-through of the granted channel while streaming.
    assign bus.tcp_tx_data_valid   = (state_q == S_STREAM) && g_valid;
    assign bus.tcp_tx_data_data    = bus.ch_data_data[DATA_WIDTH*g_q +: DATA_WIDTH];
    assign bus.tcp_tx_data_keep    = bus.ch_data_keep[KEEP_W*g_q +: KEEP_W];
    assign bus.tcp_tx_data_last    = (state_q == S_STREAM) && g_last;

endmodule

// File: tb/tb_http_tx_arbiter.sv
// Scoreboard bench for http_tx_arbiter: expected grants, TCP metas, beats and
// completions are queued when a response is offered and checked as they appear.
module tb_http_tx_arbiter;

    localparam int unsigned N  = 4;
    localparam int unsigned DW = 512;
    localparam int unsigned KW = DW / 8;
    localparam int unsigned BO = 64;
    localparam int unsigned MR = 8;
    localparam int unsigned CW = 640;
    localparam logic [CW-1:0] NONE = {1'b1, {(CW-1){1'b0}}};

    typedef struct packed {
        logic [DW-1:0] data;
        logic [KW-1:0] keep;
        logic          last;
    } beat_t;

    typedef struct packed {
        logic [1:0] err;
        logic       bogus;
    } plan_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    http_tx_arbiter_if #(.N_CH(N), .DATA_WIDTH(DW)) bus ();

    http_tx_arbiter #(
        .N_CH(N), .DATA_WIDTH(DW), .BACKOFF_CYCLES(BO), .MAX_RETRIES(MR)
    ) dut (
        .ap_clk (clk),
        .ap_rst (rst),
        .bus    (bus)
    );

    int          n_cmp = 0;
    int          n_bad = 0;
    longint      cyc = 0;
    bit          meta_pend[N];
    logic [31:0] meta_word[N];
    beat_t       pay_mem[N][16];
    int          pay_rd[N];
    int          pay_wr[N];
    logic [31:0] exp_meta[$];
    beat_t       exp_beat[$];
    int          exp_grant[$];
    int          exp_done[$];
    plan_t       plan_q[$];
    logic [63:0] stat_q[$];
    bit          bp_en;
    bit          mon_en;
    longint      last_meta_cyc;
    logic [31:0] last_meta_word;
    int          beats_seen;

    task automatic check_eq(input string tag, input logic [CW-1:0] obs, input logic [CW-1:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [16:0] out_vec();
        return {bus.ch_meta_ready, bus.ch_data_ready, bus.ch_done_valid, bus.ch_done_code,
                bus.tcp_tx_meta_valid, bus.tcp_tx_status_ready, bus.tcp_tx_data_valid};
    endfunction

    function automatic bit all_idle();
        bit idle;
        idle = (exp_meta.size() == 0) && (exp_beat.size() == 0) && (exp_grant.size() == 0)
            && (exp_done.size() == 0) && (stat_q.size() == 0);
        for (int c = 0; c < N; c++) idle = idle && !meta_pend[c] && (pay_rd[c] == pay_wr[c]);
        return idle;
    endfunction

    // fin: status error of the last attempt, after n_ns no-space attempts.
    task automatic add_resp(input int ch, input int len, input logic [15:0] sess,
                            input int n_ns, input logic [1:0] fin, input bit bogus);
        int          nb;
        int          code;
        logic [31:0] word;
        word = {16'(len), sess};
        meta_pend[ch] = 1'b1;
        meta_word[ch] = word;
        exp_grant.push_back(ch);
        if (len == 0) begin
            exp_done.push_back(ch * 4 + 3);
            return;
        end
        nb = (len + KW - 1) / KW;
        for (int b = 0; b < nb; b++) begin
            beat_t bt;
            int    bytes;
            for (int w = 0; w < DW / 32; w++) bt.data[32*w +: 32] = $urandom;
            bytes   = (b == nb - 1) ? len - KW * b : KW;
            bt.keep = '0;
            for (int k = 0; k < bytes; k++) bt.keep[k] = 1'b1;
            bt.last = (b == nb - 1);
            pay_mem[ch][pay_wr[ch] & 15] = bt;
            pay_wr[ch]++;
            if (fin == 2'd0) exp_beat.push_back(bt);
        end
        for (int t = 0; t < n_ns; t++) begin
            exp_meta.push_back(word);
            plan_q.push_back('{err: 2'd1, bogus: 1'b0});
        end
        exp_meta.push_back(word);
        plan_q.push_back('{err: fin, bogus: bogus});
        code = (fin == 2'd0) ? 0 : (fin == 2'd1) ? 1 : 2;
        exp_done.push_back(ch * 4 + code);
    endtask

    task automatic drive();
        for (int c = 0; c < N; c++) begin
            bit    pv;
            beat_t bt;
            pv = (pay_rd[c] != pay_wr[c]);
            bt = pay_mem[c][pay_rd[c] & 15];
            bus.ch_meta_valid[c]              = meta_pend[c];
            bus.ch_meta_data[32*c +: 32]      = meta_word[c];
            bus.ch_data_valid[c]              = pv;
            bus.ch_data_data[DW*c +: DW]      = bt.data;
            bus.ch_data_keep[KW*c +: KW]      = bt.keep;
            bus.ch_data_last[c]               = pv & bt.last;
        end
        bus.tcp_tx_meta_ready   = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
        bus.tcp_tx_data_ready   = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
        bus.tcp_tx_status_valid = (stat_q.size() > 0);
        bus.tcp_tx_status_data  = (stat_q.size() > 0) ? stat_q[0] : 64'd0;
    endtask

    task automatic monitor();
        if (!mon_en) return;
        if ((bus.ch_data_ready & (bus.ch_data_ready - 4'd1)) != 4'd0)
            check_eq("data_ready_onehot", CW'(bus.ch_data_ready), CW'(0));
        for (int c = 0; c < N; c++) begin
            if (bus.ch_meta_valid[c] && bus.ch_meta_ready[c]) begin
                int eg;
                eg = (exp_grant.size() > 0) ? exp_grant.pop_front() : -1;
                check_eq("grant_ch", CW'(c), CW'(eg));
                meta_pend[c] = 1'b0;
            end
            if (bus.ch_data_valid[c] && bus.ch_data_ready[c]) pay_rd[c]++;
        end
        if (bus.tcp_tx_meta_valid && bus.tcp_tx_meta_ready) begin
            logic [CW-1:0] em;
            em = (exp_meta.size() > 0) ? CW'(exp_meta.pop_front()) : NONE;
            check_eq("tx_meta", CW'(bus.tcp_tx_meta_data), em);
            if (bus.tcp_tx_meta_data == last_meta_word)
                check_eq("retry_gap_ge_backoff", CW'(cyc - last_meta_cyc >= longint'(BO)), CW'(1));
            last_meta_cyc  = cyc;
            last_meta_word = bus.tcp_tx_meta_data;
            if (plan_q.size() > 0) begin
                plan_t p;
                p = plan_q.pop_front();
                if (p.bogus) stat_q.push_back({2'd0, 30'd0, bus.tcp_tx_meta_data ^ 32'h0000_8000});
                stat_q.push_back({p.err, 30'd0, bus.tcp_tx_meta_data});
            end
        end
        if (bus.tcp_tx_status_valid && bus.tcp_tx_status_ready && stat_q.size() > 0)
            void'(stat_q.pop_front());
        if (bus.tcp_tx_data_valid) begin
            if (exp_beat.size() == 0) begin
                check_eq("tx_valid_spurious", CW'(bus.tcp_tx_data_valid), CW'(0));
            end else if (bus.tcp_tx_data_ready) begin
                beat_t eb;
                eb = exp_beat.pop_front();
                check_eq("tx_beat", CW'({bus.tcp_tx_data_data, bus.tcp_tx_data_keep, bus.tcp_tx_data_last}),
                         CW'(eb));
                beats_seen++;
            end
        end
        if (bus.ch_done_valid != 4'd0) begin
            int c;
            int ed;
            c = 0;
            for (int i = N - 1; i >= 0; i--) if (bus.ch_done_valid[i]) c = i;
            if ((bus.ch_done_valid & (bus.ch_done_valid - 4'd1)) != 4'd0)
                check_eq("done_onehot", CW'(bus.ch_done_valid), CW'(4'd1) << c);
            ed = (exp_done.size() > 0) ? exp_done.pop_front() : -1;
            check_eq("done_ch_code", CW'(c * 4 + int'(bus.ch_done_code)), CW'(ed));
        end
    endtask

    task automatic step();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
        cyc++;
        drive();
    endtask

    task automatic drain(input string tag, input int budget);
        int n;
        n = 0;
        while (!all_idle() && n < budget) begin
            step();
            n++;
        end
        repeat (3) step();
        check_eq({tag, "_drained"}, CW'(all_idle()), CW'(1));
    endtask

    initial begin
        rst    = 1'b1;
        mon_en = 1'b1;
        bp_en  = 1'b0;
        last_meta_word = 32'hFFFF_FFFF;
        beats_seen = 0;
        for (int c = 0; c < N; c++) begin
            meta_pend[c] = 1'b0;
            meta_word[c] = 32'd0;
            pay_rd[c] = 0;
            pay_wr[c] = 0;
        end
        drive();
        repeat (3) step();
        @(negedge clk);
        check_eq("reset_outputs", CW'(out_vec()), CW'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Two full rounds with every channel requesting: 0,1,2,3 then wrap to 0.
        for (int c = 0; c < N; c++) add_resp(c, 64, 16'h0010 + 16'(c), 0, 2'd0, 1'b0);
        drain("round1", 400);
        for (int c = 0; c < N; c++) add_resp(c, 64, 16'h0020 + 16'(c), 0, 2'd0, 1'b0);
        drain("round2", 400);

        add_resp(0, 128, 16'h0005, 0, 2'd0, 1'b0);
        drain("single", 200);

        add_resp(1, 192, 16'h0030, 2, 2'd0, 1'b0);
        drain("retry_ok", 600);

        add_resp(2, 128, 16'h0040, MR, 2'd1, 1'b0);
        drain("retry_drop", 1500);

        add_resp(3, 100, 16'h0050, 0, 2'd2, 1'b1);
        drain("no_conn", 200);

        add_resp(0, 0, 16'h0060, 0, 2'd0, 1'b0);
        drain("zero_len", 100);
        add_resp(1, 0, 16'h0061, 0, 2'd0, 1'b0);
        add_resp(2, 64, 16'h0062, 0, 2'd0, 1'b0);
        drain("zero_mixed", 200);

        bp_en = 1'b1;
        add_resp(3, 320, 16'h0070, 0, 2'd0, 1'b0);
        add_resp(1, 256, 16'h0071, 0, 2'd0, 1'b0);
        drain("backpressure", 800);

        // Reset in the middle of a stream, with requests left pending across it.
        begin
            int target;
            int n;
            target = beats_seen + 2;
            add_resp(1, 256, 16'h0080, 0, 2'd0, 1'b0);
            n = 0;
            while (beats_seen < target && n < 500) begin
                step();
                n++;
            end
            check_eq("reached_stream", CW'(beats_seen >= target), CW'(1));
        end
        mon_en = 1'b0;
        rst    = 1'b1;
        for (int c = 0; c < N; c++) begin
            meta_pend[c] = 1'b0;
            pay_rd[c]    = pay_wr[c];
        end
        exp_meta.delete();
        exp_beat.delete();
        exp_grant.delete();
        exp_done.delete();
        plan_q.delete();
        stat_q.delete();
        add_resp(0, 64, 16'h0082, 0, 2'd0, 1'b0);
        add_resp(2, 128, 16'h0081, 0, 2'd0, 1'b0);
        drive();
        @(posedge clk);
        @(negedge clk);
        check_eq("reset_mid_outputs", CW'(out_vec()), CW'(0));
        @(posedge clk);
        #1;
        rst    = 1'b0;
        mon_en = 1'b1;
        last_meta_word = 32'hFFFF_FFFF;
        drive();
        drain("after_reset", 800);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/http_tx_arbiter.md
Name: http_tx_arbiter

Overview:
- Multi-channel HTTP response transmit arbiter between N response producers and the TCP offload engine's transmit interface.
- Round-robin selects a channel's response meta and issues tcp_tx_meta. Waits for tcp_tx_status, then streams that channel's payload, retries after a backoff, or drops the payload, depending on status.
- Parametrised successor of the single-channel HTTP/TCP glue: adds channel count, data width, retry/backoff policy and per-channel completion reporting.

Parameters:
N_CH, 4, number of response channels (1..16)
DATA_WIDTH, 512, TCP/channel data bus width in bits (multiple of 64)
BACKOFF_CYCLES, 64, idle cycles between retries after a "no space" status
MAX_RETRIES, 8, retries before a no-space response is dropped

Ports:
ap_clk  in  1  clock
ap_rst  in  1  synchronous active-high reset
ch_meta_valid  in  N_CH  per-channel response request
ch_meta_ready  out  N_CH  request accepted
ch_meta_data  in  32*N_CH  per channel {length[31:16] bytes, session[15:0]}
ch_data_valid  in  N_CH  payload valid
ch_data_ready  out  N_CH  payload ready
ch_data_data  in  DATA_WIDTH*N_CH  payload
ch_data_keep  in  DATA_WIDTH/8*N_CH  byte enables
ch_data_last  in  N_CH  last payload beat
ch_done_valid  out  N_CH  one-cycle completion pulse
ch_done_code  out  2  completion code of pulsing channel: 0 sent, 1 dropped-no-space, 2 dropped-no-connection, 3 rejected-zero-length
tcp_tx_meta_valid/ready/data  out/in/out  1/1/32  {length, session}
tcp_tx_status_valid/ready/data  in/out/in  1/1/64  {error[63:62], space[61:32], length[31:16], session[15:0]}
tcp_tx_data_valid/ready  out/in  1/1
tcp_tx_data_data/keep/last  out  DATA_WIDTH/DATA_WIDTH/8/1

Behaviour:
- Reset: all valid/ready outputs 0, ch_done_code 0, round-robin pointer 0, retry counter 0, state IDLE. Any in-flight transaction is abandoned with no done pulse. Reset mid-STREAM may truncate the TCP packet; that is acceptable.
- IDLE: if any ch_meta_valid, grant the lowest index at or after the pointer (wrapping). Latch session/length and assert ch_meta_ready[g] for exactly one cycle. Pointer becomes g+1 mod N_CH. Go to META; tcp_tx_meta_valid rises the cycle after grant.
- Zero length: consume meta, pulse done code 3 the next cycle, return to IDLE. No TCP traffic.
- META: hold tcp_tx_meta_valid and data stable until ready, then go to STATUS.
- STATUS: tcp_tx_status_ready=1. On a status whose session/length match the latched values:
  - error 0: go to STREAM.
  - error 1: if retries < MAX_RETRIES, increment retries and go to BACKOFF; else go to DROP with code 1.
  - error 2 or 3: go to DROP with code 2.
- Status mismatch: discard it and stay in STATUS. Increment the sticky 8-bit saturating mismatch counter (internal, debug only).
- BACKOFF: count BACKOFF_CYCLES, then go to META with the same session/length. Other channels are not served meanwhile.
- STREAM: combinational pass-through of granted channel g: tcp_tx_data_valid=ch_data_valid[g], ch_data_ready[g]=tcp_tx_data_ready; data/keep/last forwarded. On the last-beat handshake, pulse done code 0 and go to IDLE.
- DROP: ch_data_ready[g]=1 and tcp_tx_data_valid=0 until the last beat is consumed. Pulse done with the stored code, go to IDLE.
- Retry counter clears on every new grant.
- At most one done pulse per cycle. Non-granted channels see ready=0 at all times.
- Throughput: one beat per cycle in STREAM. Minimum per-response overhead is 3 cycles (grant, meta, status).

Decomposition:
- Shared package: tx_meta and tx_status packed struct typedefs, error code enum (OK, NO_SPACE, NO_CONN, RESERVED), done code enum.
- Sub-module rr_arbiter (parametrised N, request vector plus pointer in, one-hot grant plus index out, combinational). The FSM and datapath mux live in the top.

Test Plan:
- Single channel 0, session 0x0005, length 128, DATA_WIDTH 512 -> tx_meta data 0x00800005; status error 0; 2 beats forwarded unchanged; done[0] code 0.
- Channels 0–3 all requesting at once, lengths 64 -> grant order 0,1,2,3. Next round after new requests starts at 0 with the pointer at 0 after wrap.
- Status error 1 twice, then 0 -> tx_meta issued 3 times, gaps of at least 64 cycles, payload sent once, code 0.
- Status error 1 nine times with MAX_RETRIES 8 -> 9 meta issues, payload fully drained with tcp_tx_data_valid never high, done code 1.
- Status error 2 -> payload drained, code 2. Zero-length meta -> code 3, no tx_meta.
- Random backpressure on tcp_tx_data_ready and tcp_tx_meta_ready (50%) plus assertion of ap_rst mid-STREAM -> data order preserved, outputs 0 the cycle after reset, next grant starts from channel 0.
